// File: rtl/strike_detector.sv
// strike_detector: detects pitch-rate swings (rise above HIGH_TH, fall below LOW_TH) and
// reports each strike with its yaw zone, peak velocity and a running count.
module strike_detector #(
  parameter logic [15:0] HIGH_TH   = 16'd8000,
  parameter logic [15:0] LOW_TH    = 16'd1500,
  parameter logic [7:0]  MAX_SWING = 8'd50,
  parameter logic [7:0]  HOLDOFF   = 8'd10,
  parameter logic [15:0] YAW_SPLIT = 16'd4000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_strobe,
  input  logic               initialized,
  input  logic               error,
  input  logic               gyro_valid,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] yaw,
  output logic               strike,
  output logic [1:0]         strike_zone,
  output logic [7:0]         strike_velocity,
  output logic [15:0]        strike_count,
  output logic               busy
);
  localparam logic [7:0] MAX_SW = (MAX_SWING == 8'd0) ? 8'd1 : MAX_SWING;
  localparam logic [7:0] HOLD_N = (HOLDOFF == 8'd0) ? 8'd1 : HOLDOFF;
  localparam logic signed [16:0] SPLIT = {1'b0, YAW_SPLIT};
  typedef enum logic [1:0] {IDLE, SWING, HOLD} state_t;
  state_t state, state_n;
  logic [15:0] peak, peak_n, count_n, mag;
  logic [7:0] swing_cnt, swing_n, hold_cnt, hold_n, vel_n;
  logic [1:0] zone_n, zone_now;
  logic strike_n, good;
  logic signed [16:0] yaw_x;
  assign good = sample_strobe & initialized & ~error & gyro_valid;
  assign mag = (gyro_y == -16'sd32768) ? 16'h7fff : gyro_y[15] ? 16'(-gyro_y) : gyro_y;
  assign yaw_x = {yaw[15], yaw};
  assign zone_now = (yaw_x < -SPLIT) ? 2'd0 : (yaw_x > SPLIT) ? 2'd2 : 2'd1;
  assign busy = (state != IDLE);
  always_comb begin
    state_n = state;
    peak_n = peak;
    swing_n = swing_cnt;
    hold_n = hold_cnt;
    strike_n = 1'b0;
    zone_n = strike_zone;
    vel_n = strike_velocity;
    count_n = strike_count;
    if (sample_strobe && !good) begin
      state_n = IDLE;
      peak_n = '0;
      swing_n = '0;
      hold_n = '0;
    end else if (good) begin
      case (state)
        IDLE: if (mag >= HIGH_TH) begin
          state_n = SWING;
          peak_n = mag;
          swing_n = 8'd1;
        end
        SWING: if (mag >= LOW_TH) begin
          // a swing already MAX_SW samples long is abandoned rather than extended
          if (swing_cnt >= MAX_SW) begin
            state_n = IDLE;
            peak_n = '0;
            swing_n = '0;
          end else begin
            peak_n = (mag > peak) ? mag : peak;
            swing_n = swing_cnt + 8'd1;
          end
        end else begin
          state_n = HOLD;
          strike_n = 1'b1;
          vel_n = peak[14:7];
          zone_n = zone_now;
          count_n = strike_count + 16'd1;
          peak_n = '0;
          swing_n = '0;
          hold_n = '0;
        end
        HOLD: begin
          hold_n = hold_cnt + 8'd1;
          if (hold_n >= HOLD_N) begin
            state_n = IDLE;
            hold_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      peak <= '0;
      swing_cnt <= '0;
      hold_cnt <= '0;
      strike <= 1'b0;
      strike_zone <= 2'd1;
      strike_velocity <= '0;
      strike_count <= '0;
    end else begin
      state <= state_n;
      peak <= peak_n;
      swing_cnt <= swing_n;
      hold_cnt <= hold_n;
      strike <= strike_n;
      strike_zone <= zone_n;
      strike_velocity <= vel_n;
      strike_count <= count_n;
    end
  end
endmodule

// File: tb/tb_strike_detector.sv
// tb_strike_detector: scoreboard bench; a queue-based reference model predicts the
// response to every strobe and a monitor compares one cycle later.
module tb_strike_detector;
  logic clk = 0, rst = 1, sample_strobe = 0, initialized = 0, error = 0, gyro_valid = 0;
  logic signed [15:0] gyro_y = 0, yaw = 0;
  logic strike, busy;
  logic [1:0] strike_zone;
  logic [7:0] strike_velocity;
  logic [15:0] strike_count;
  typedef struct {logic s; logic [1:0] z; logic [7:0] v; logic [15:0] c; logic b;} exp_t;
  exp_t q[$];
  int n_checks = 0, n_pass = 0;
  int m_st = 0, m_hold = 0, m_zone = 1, m_vel = 0, m_cnt = 0;
  int swing_q[$];
  logic strobe_d = 0;

  strike_detector dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .initialized(initialized),
    .error(error), .gyro_valid(gyro_valid), .gyro_y(gyro_y), .yaw(yaw),
    .strike(strike), .strike_zone(strike_zone), .strike_velocity(strike_velocity),
    .strike_count(strike_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got s=%0b z=%0d v=%0d c=%0d b=%0b", nm, strike, strike_zone,
                  strike_velocity, strike_count, busy);
  endtask

  always @(posedge clk) strobe_d = sample_strobe && !rst;

  always @(negedge clk) if (!rst) begin
    if (strobe_d) begin
      if (q.size() == 0) chk(1'b0, "unexpected_response");
      else begin
        exp_t e;
        e = q.pop_front();
        n_checks++;
        if (strike === e.s && strike_zone === e.z && strike_velocity === e.v &&
            strike_count === e.c && busy === e.b) n_pass++;
        else $display("FAIL sample: got s=%0b z=%0d v=%0d c=%0d b=%0b want s=%0b z=%0d v=%0d c=%0d b=%0b",
                      strike, strike_zone, strike_velocity, strike_count, busy,
                      e.s, e.z, e.v, e.c, e.b);
      end
    end else chk(strike === 1'b0, "no_pulse_between_strobes");
  end

  task automatic model_reset();
    m_st = 0; m_hold = 0; m_zone = 1; m_vel = 0; m_cnt = 0;
    swing_q.delete();
  endtask

  task automatic send(input bit ini, input bit err, input bit gv, input int gy, input int yw);
    exp_t e;
    int mag, pk;
    bit good;
    @(negedge clk);
    initialized = ini; error = err; gyro_valid = gv;
    gyro_y = 16'(gy); yaw = 16'(yw); sample_strobe = 1;
    good = ini && !err && gv;
    mag = gy < 0 ? -gy : gy;
    if (mag > 32767) mag = 32767;
    e.s = 0;
    if (!good) begin
      m_st = 0; m_hold = 0; swing_q.delete();
    end else if (m_st == 0) begin
      if (mag >= 8000) begin m_st = 1; swing_q = {mag}; end
    end else if (m_st == 1) begin
      if (mag >= 1500) begin
        if (swing_q.size() >= 50) begin m_st = 0; swing_q.delete(); end
        else swing_q.push_back(mag);
      end else begin
        pk = 0;
        foreach (swing_q[i]) if (swing_q[i] > pk) pk = swing_q[i];
        m_vel = (pk / 128) % 256;
        m_zone = yw < -4000 ? 0 : yw > 4000 ? 2 : 1;
        m_cnt = (m_cnt + 1) % 65536;
        m_st = 2; m_hold = 0; swing_q.delete();
        e.s = 1;
      end
    end else begin
      m_hold++;
      if (m_hold >= 10) m_st = 0;
    end
    e.z = 2'(m_zone); e.v = 8'(m_vel); e.c = 16'(m_cnt); e.b = (m_st != 0);
    q.push_back(e);
    @(negedge clk);
    sample_strobe = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic g(input int gy, input int yw);
    send(1, 0, 1, gy, yw);
  endtask

  task automatic holdoff();
    repeat (10) g(0, 0);
  endtask

  task automatic reset_check();
    @(negedge clk);
    #2 rst = 1;
    #1 chk(strike === 0 && busy === 0 && strike_zone === 2'd1 && strike_velocity === 0 &&
           strike_count === 0, "async_reset");
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  function automatic int rgy();
    case ($urandom_range(0, 5))
      0: return int'($urandom_range(0, 1499));
      1: return int'($urandom_range(1500, 7999));
      2: return int'($urandom_range(8000, 32767));
      3: return -int'($urandom_range(8000, 32767));
      4: return -32768;
      default: return -int'($urandom_range(0, 7999));
    endcase
  endfunction

  function automatic int ryaw();
    int b[6] = '{-4001, -4000, 4000, 4001, -32768, 32767};
    return $urandom_range(0, 3) == 0 ? b[$urandom_range(0, 5)] : int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 chk(strike === 0 && busy === 0 && strike_zone === 2'd1 && strike_velocity === 0 &&
           strike_count === 0, "reset_values");
    @(negedge clk);
    rst = 0;
    g(0, 0); g(9000, 0); g(20000, 0); g(1000, 0);
    chk(strike_velocity === 156 && strike_zone === 1 && strike_count === 1 && busy === 1, "basic_strike");
    holdoff();
    g(0, -5000); g(-9000, -5000); g(-20000, -5000); g(-1000, -5000);
    chk(strike_zone === 0 && strike_count === 2, "zone_left");
    holdoff();
    g(0, 5000); g(9000, 5000); g(20000, 5000); g(1000, 5000);
    chk(strike_zone === 2 && strike_count === 3, "zone_right");
    repeat (10) g(20000, 0);
    chk(busy === 0 && strike_count === 3, "holdoff_end");
    g(20000, 0);
    chk(busy === 1, "swing_after_holdoff");
    g(1000, 0);
    holdoff();
    g(9000, 0);
    repeat (50) g(9000, 0);
    chk(busy === 0 && strike_count === 4, "swing_timeout");
    g(20000, 0); send(1, 1, 1, 0, 0); g(0, 0);
    chk(busy === 0 && strike_count === 4, "error_abort");
    g(20000, 0); send(1, 0, 0, 0, 0); g(0, 0);
    chk(busy === 0 && strike_count === 4, "invalid_abort");
    g(-32768, 0); g(0, 0);
    chk(strike_velocity === 255 && strike_count === 5, "saturated_peak");
    g(0, 0); g(0, 0);
    reset_check();
    g(20000, 0);
    reset_check();
    g(1000, 0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 19))
        0: send(0, 0, 1, rgy(), ryaw());
        1: send(1, 1, 1, rgy(), ryaw());
        2: send(1, 0, 0, rgy(), ryaw());
        default: g(rgy(), ryaw());
      endcase
    end
    repeat (4) @(negedge clk);
    chk(q.size() == 0, "scoreboard_drained");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/strike_detector.md
STRIKE_DETECTOR -- requirements
Module: strike_detector

Interface
REQ-001 SHALL have parameter HIGH_TH, default 16'd8000, the |gyro_y| level (unsigned) that opens a swing.
REQ-002 SHALL have parameter LOW_TH, default 16'd1500, the |gyro_y| level (unsigned) below which an open swing completes as a strike.
REQ-003 SHALL have parameter MAX_SWING, default 8'd50, the maximum number of samples a swing may stay open before it is aborted.
REQ-004 SHALL have parameter HOLDOFF, default 8'd10, the number of samples ignored after a strike.
REQ-005 SHALL have parameter YAW_SPLIT, default 16'd4000, the yaw magnitude that separates the centre zone from the side zones.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port sample_strobe, input, 1 bit: one-cycle pulse marking that a new sensor sample is present on the data inputs.
REQ-009 SHALL have port initialized, input, 1 bit: the sensor link has received a good header.
REQ-010 SHALL have port error, input, 1 bit: the sensor link has seen a bad header.
REQ-011 SHALL have port gyro_valid, input, 1 bit: the gyro fields are valid.
REQ-012 SHALL have port gyro_y, input, signed 16 bits: pitch-axis angular rate.
REQ-013 SHALL have port yaw, input, signed 16 bits: yaw angle (the quat_z field).
REQ-014 SHALL have port strike, output, 1 bit: one-cycle strike pulse.
REQ-015 SHALL have port strike_zone, output, 2 bits: zone of the last strike (0 left, 1 centre, 2 right).
REQ-016 SHALL have port strike_velocity, output, 8 bits: peak rate of the last strike.
REQ-017 SHALL have port strike_count, output, 16 bits: total strikes since reset.
REQ-018 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-019 SHALL treat a sample as good only when sample_strobe=1, initialized=1, error=0 and gyro_valid=1; no state, counter or peak SHALL change on cycles without sample_strobe.
REQ-020 SHALL compute mag = |gyro_y| as 16-bit unsigned, with -32768 saturating to 32767.
REQ-021 SHALL implement states IDLE, SWING and HOLD, all updated on the clk rising edge.
REQ-022 In IDLE, a good sample with mag >= HIGH_TH SHALL move the block to SWING, set peak=mag and set swing_cnt=1.
REQ-023 In SWING, a good sample with mag >= LOW_TH SHALL set peak=max(peak,mag) and increment swing_cnt.
- If swing_cnt reaches MAX_SWING, the block SHALL return to IDLE with no strike.
REQ-024 In SWING, a good sample with mag < LOW_TH SHALL register a strike and enter HOLD with hold_cnt=0.
- The strike pulse SHALL be high exactly one cycle, in the cycle after the strobe.
- strike_velocity SHALL be set to peak[14:7].
- strike_zone SHALL be set from yaw of that same sample: yaw < -YAW_SPLIT gives 0, yaw > YAW_SPLIT gives 2, otherwise 1 (signed comparisons).
- strike_count SHALL increment, wrapping from 0xFFFF to 0x0000.
REQ-025 In HOLD, each good sample SHALL increment hold_cnt; when hold_cnt reaches HOLDOFF the block SHALL return to IDLE.
- The sample that ends HOLD SHALL NOT open a swing; it is evaluated by the IDLE rules only from the next sample.
REQ-026 A strobed sample that is not good SHALL force IDLE from any state, with no strike, and SHALL clear peak and both counters.
REQ-027 strike_zone, strike_velocity and strike_count SHALL hold their values between strikes.
REQ-028 MAX_SWING=0 or HOLDOFF=0 SHALL behave as 1.

Reset
REQ-029 rst=1 SHALL asynchronously force the following, regardless of clk:
- state IDLE;
- strike=0, busy=0;
- strike_zone=2'd1;
- strike_velocity=0, strike_count=0;
- peak, swing_cnt and hold_cnt cleared.
REQ-030 A reset asserted mid-SWING or mid-HOLD SHALL discard the swing in progress; no strike SHALL be produced after reset is released.

Verification
REQ-031 Good samples gyro_y = 0, 9000, 20000, 1000 with yaw=0 -> exactly one strike pulse one cycle after the 4th strobe, strike_velocity=156, strike_zone=1, strike_count=1, busy=1.
REQ-032 Same stimulus with gyro_y negated and yaw=-5000, then yaw=+5000 on a second swing after holdoff -> zones 0 then 2, strike_count=2.
REQ-033 After a strike, send 10 good samples all with gyro_y=20000 -> no strike, state IDLE after the 10th; the 11th sample opens a swing.
REQ-034 Open a swing, then 50 good samples with gyro_y=9000 -> return to IDLE, no strike, strike_count unchanged.
REQ-035 Open a swing, then a strobe with error=1 (or gyro_valid=0) followed by gyro_y=0 -> no strike, busy=0; separately, gyro_y=-32768 followed by 0 -> strike_velocity=255.
REQ-036 Assert rst during HOLD with strike_count=5 -> all outputs at reset values immediately, without waiting for clk; strike_count=0.
